// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM states and access-legality helpers for the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_e;

    // Unsigned variants exist only for sub-word loads.
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load lane extraction with sign/zero extension, and sub-word store merge into a read word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  f3_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bm;
    logic [31:0] hm;

    always_comb begin
        b = old_i[{lane_i, 3'b000} +: 8];
        h = lane_i[1] ? old_i[31:16] : old_i[15:0];
        bm = 32'h0000_00ff << {lane_i, 3'b000};
        hm = 32'h0000_ffff << {lane_i[1], 4'b0000};
        load_o = f3_i == F3_B  ? {{24{b[7]}}, b} :
                 f3_i == F3_BU ? {24'b0, b} :
                 f3_i == F3_H  ? {{16{h[15]}}, h} :
                 f3_i == F3_HU ? {16'b0, h} : old_i;
        // Replicating the new data across lanes lets the mask alone pick the target lane.
        merge_o = f3_i[1:0] == 2'b00 ? (old_i & ~bm) | ({4{new_i[7:0]}} & bm) :
                  f3_i[1:0] == 2'b01 ? (old_i & ~hm) | ({2{new_i[15:0]}} & hm) : new_i;
    end
endmodule

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: single-outstanding RV32I load/store initiator driving a word-wide memory port,
// using read-modify-write for byte and halfword stores.
module lsu_mem_if
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_r_enable,
    output logic        mem_w_enable,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    state_e      state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] load_w;
    logic [31:0] merge_w;
    logic        accept;
    logic        bad;

    assign accept = state_q == IDLE && req_valid;
    assign bad = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .old_i   (mem_rdata),
        .new_i   (wword_q),
        .lane_i  (addr_q[1:0]),
        .f3_i    (f3_q),
        .load_o  (load_w),
        .merge_o (merge_w)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = bad ? RESP : (req_we && req_funct3[1:0] == 2'b10) ? WR : RD;
            RD:      state_d = CAP;
            CAP:     state_d = we_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // wword_q holds the raw store data until CAP replaces it with the merged word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'b0;
            wword_q <= 32'b0;
            rdata_q <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wword_q <= req_wdata;
                rdata_q <= 32'b0;
                err_q   <= bad;
            end
            if (state_q == CAP) begin
                if (we_q) wword_q <= merge_w;
                else      rdata_q <= load_w;
            end
        end
    end

    assign req_ready    = state_q == IDLE;
    assign resp_valid   = state_q == RESP;
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_r_enable = state_q == RD;
    assign mem_w_enable = state_q == WR;
    assign mem_wdata    = wword_q;
endmodule

// File: tb/tb_lsu_mem_if.sv
// tb_lsu_mem_if: directed and randomized checks of lsu_mem_if against a byte-level memory model.
module tb_lsu_mem_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_r_enable;
    logic        mem_w_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_if dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_r_enable (mem_r_enable),
        .mem_w_enable (mem_w_enable),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    logic [31:0] mem [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = 8'b0;
    logic [31:0] pl_data = 32'b0;
    logic [31:0] ref_mem [256];
    int r_cnt = 0;
    int w_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] <= pl_data;
        if (mem_r_enable) mem_rdata <= mem[mem_addr[9:2]];
        if (mem_w_enable) mem[mem_addr[9:2]] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_r_enable) r_cnt++;
        if (mem_w_enable) w_cnt++;
    end

    always @(negedge clk) begin
        checks++;
        if ((mem_r_enable && mem_w_enable) || mem_addr[1:0] != 2'b00) begin
            errors++;
            $display("FAIL port_rules r=%0b w=%0b addr=%h (want one strobe max, aligned addr)", mem_r_enable, mem_w_enable, mem_addr);
        end
    end

    function automatic int acc_size(input logic [2:0] f3);
        return f3[1:0] == 2'b11 ? 0 : 1 << f3[1:0];
    endfunction

    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        sz = acc_size(f3);
        if (sz == 0 || (f3[2] && (we || sz == 4))) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        logic [63:0] v;
        logic [63:0] m;
        sz = acc_size(f3);
        m = (64'd1 << (8 * sz)) - 64'd1;
        v = ({32'b0, ref_mem[a[9:2]]} >> (8 * int'(a[1:0]))) & m;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz;
        sz = acc_size(f3);
        for (int i = 0; i < sz; i++) ref_mem[a[9:2]][8 * (int'(a[1:0]) + i) +: 8] = d[8 * i +: 8];
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int hold, output logic [31:0] rd, output logic er, output int lat,
                           output int nr, output int nw, output int unstable);
        int r0;
        int w0;
        resp_ready = (hold == 0);
        @(negedge clk);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = d;
        r0 = r_cnt;
        w0 = w_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        unstable = 0;
        @(negedge clk);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready || mem_r_enable || mem_w_enable) unstable++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        nr = r_cnt - r0;
        nw = w_cnt - w0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_r_enable, mem_w_enable} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=10000", {req_ready, resp_valid, resp_err, mem_r_enable, mem_w_enable});
        end
        checks++;
        if (mem_addr !== 32'b0 || mem_wdata !== 32'b0 || resp_rdata !== 32'b0) begin
            errors++;
            $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, resp_rdata);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_idx = 8'(i);
            pl_data = (i == 'h67) ? 32'hFF0F0E0D : $urandom;
            ref_mem[i] = pl_data;
            pl_we = 1'b1;
        end
        @(negedge clk);
        pl_we = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
        logic [31:0] as  [4] = '{32'h19F, 32'h19F, 32'h19E, 32'h19C};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFFFF0F, 32'hFF0F0E0D};
        logic [31:0] rd;
        logic er;
        int lat, nr, nw, us;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, f3s[i], as[i], 32'b0, 0, rd, er, lat, nr, nw, us);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_%0d rdata=%h err=%b exp=%h err=0", i, rd, er, exp[i]);
            end
            checks++;
            if (lat != 3 || nr != 1 || nw != 0) begin
                errors++;
                $display("FAIL load_timing_%0d lat=%0d rd=%0d wr=%0d exp lat=3 rd=1 wr=0", i, lat, nr, nw);
            end
        end
    endtask

    task automatic test_errors();
        logic        wes [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] as  [3] = '{32'h19A, 32'h19D, 32'h19C};
        logic [31:0] rd;
        logic er;
        int lat, nr, nw, us;
        for (int i = 0; i < 3; i++) begin
            run_req(wes[i], f3s[i], as[i], 32'hDEADBEEF, 0, rd, er, lat, nr, nw, us);
            checks++;
            if (er !== 1'b1 || rd !== 32'b0) begin
                errors++;
                $display("FAIL err_%0d err=%b rdata=%h exp err=1 rdata=0", i, er, rd);
            end
            checks++;
            if (lat != 1 || nr != 0 || nw != 0) begin
                errors++;
                $display("FAIL err_timing_%0d lat=%0d rd=%0d wr=%0d exp lat=1 rd=0 wr=0", i, lat, nr, nw);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic er;
        int lat, nr, nw, us;
        run_req(1'b0, 3'b010, 32'h19C, 32'b0, 5, rd, er, lat, nr, nw, us);
        checks++;
        if (us != 0 || rd !== 32'hFF0F0E0D || nr != 1 || nw != 0) begin
            errors++;
            $display("FAIL backpressure unstable=%0d rdata=%h rd=%0d wr=%0d exp 0 FF0F0E0D 1 0", us, rd, nr, nw);
        end
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release ready=%b valid=%b exp 1 0", req_ready, resp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat, nr, nw, us, w0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b000;
        req_addr = 32'h19D;
        req_wdata = 32'hAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        w0 = w_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_r_enable, mem_w_enable} !== 5'b10000 ||
            mem_addr !== 32'b0 || mem_wdata !== 32'b0 || resp_rdata !== 32'b0) begin
            errors++;
            $display("FAIL mid_reset ctrl=%b addr=%h wdata=%h rdata=%h exp 10000 and zeros",
                     {req_ready, resp_valid, resp_err, mem_r_enable, mem_w_enable}, mem_addr, mem_wdata, resp_rdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (w_cnt != w0) begin
            errors++;
            $display("FAIL mid_reset_write writes=%0d exp 0", w_cnt - w0);
        end
        run_req(1'b0, 3'b010, 32'h19C, 32'b0, 0, rd, er, lat, nr, nw, us);
        checks++;
        if (rd !== 32'hFF0F0E0D || er !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_reload rdata=%h err=%b exp FF0F0E0D 0", rd, er);
        end
    endtask

    task automatic test_stores();
        logic [31:0] rd;
        logic er;
        int lat, nr, nw, us;
        run_req(1'b1, 3'b000, 32'h19D, 32'h123456AA, 0, rd, er, lat, nr, nw, us);
        ref_store(3'b000, 32'h19D, 32'h123456AA);
        checks++;
        if (lat != 4 || nr != 1 || nw != 1 || er !== 1'b0 || rd !== 32'b0) begin
            errors++;
            $display("FAIL sb lat=%0d rd=%0d wr=%0d err=%b rdata=%h exp 4 1 1 0 0", lat, nr, nw, er, rd);
        end
        run_req(1'b0, 3'b010, 32'h19C, 32'b0, 0, rd, er, lat, nr, nw, us);
        checks++;
        if (rd !== 32'hFF0FAA0D) begin
            errors++;
            $display("FAIL sb_readback rdata=%h exp FF0FAA0D", rd);
        end
        run_req(1'b1, 3'b010, 32'h1A0, 32'h12345678, 0, rd, er, lat, nr, nw, us);
        ref_store(3'b010, 32'h1A0, 32'h12345678);
        checks++;
        if (lat != 2 || nr != 0 || nw != 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw lat=%0d rd=%0d wr=%0d err=%b exp 2 0 1 0", lat, nr, nw, er);
        end
        run_req(1'b0, 3'b010, 32'h1A0, 32'b0, 0, rd, er, lat, nr, nw, us);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL sw_readback rdata=%h exp 12345678", rd);
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a, d, rd, exp_rd;
        logic er, exp_er;
        int lat, nr, nw, us, hold, exp_lat, exp_nr, exp_nw;
        for (int n = 0; n < 120; n++) begin
            we = 1'($urandom);
            f3 = 3'($urandom);
            a = 32'h180 + 32'($urandom_range(0, 63));
            d = $urandom;
            hold = $urandom_range(0, 2);
            exp_er = ref_err(we, f3, a);
            exp_rd = (exp_er || we) ? 32'b0 : ref_load(f3, a);
            exp_lat = exp_er ? 1 : !we ? 3 : acc_size(f3) == 4 ? 2 : 4;
            exp_nr = (exp_er || (we && acc_size(f3) == 4)) ? 0 : 1;
            exp_nw = (!exp_er && we) ? 1 : 0;
            run_req(we, f3, a, d, hold, rd, er, lat, nr, nw, us);
            if (!exp_er && we) ref_store(f3, a, d);
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL rand_%0d we=%b f3=%b a=%h rdata=%h err=%b exp %h %b", n, we, f3, a, rd, er, exp_rd, exp_er);
            end
            checks++;
            if (lat != exp_lat || nr != exp_nr || nw != exp_nw || us != 0) begin
                errors++;
                $display("FAIL rand_timing_%0d we=%b f3=%b lat=%0d rd=%0d wr=%0d unstable=%0d exp %0d %0d %0d 0",
                         n, we, f3, lat, nr, nw, us, exp_lat, exp_nr, exp_nw);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_stores();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store initiator between the core's execute stage and the word-wide data memory port (`mem_addr`, `mem_r_enable`, `mem_w_enable`, `mem_wdata`, `mem_rdata`).
- Accepts one RV32I load/store request at a time and drives the memory port.
- Byte and halfword stores use read-modify-write, because the memory writes whole words only.
- Load data is extracted and sign/zero-extended here.
- Misaligned and illegal accesses are reported as errors without touching memory.

## Interface
Parameters:
- none; data and address widths are fixed at 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned (`rs2`).
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  32  extended load result (0 for stores and errors).
- `resp_err`  out  1  misaligned or illegal funct3.
- `mem_addr`  out  32  word-aligned byte address; bits [1:0] are always 0.
- `mem_r_enable`  out  1  read strobe; memory registers `mem_rdata` on this edge.
- `mem_w_enable`  out  1  write strobe; `mem_wdata` is written on this edge.
- `mem_wdata`  out  32  full word to write.
- `mem_rdata`  in  32  word read data, valid the cycle after `mem_r_enable`.

## Operation
States:
- IDLE: `req_ready`=1. On `req_valid` it latches we/funct3/addr/wdata, then goes to:
  - RESP with `resp_err`=1 if the request is illegal or misaligned;
  - WR for SW;
  - RD for any load or SB/SH.
- RD: `mem_r_enable`=1 → CAP.
- CAP: sample `mem_rdata`.
  - Load: extract and extend → RESP.
  - Sub-word store: merge the new byte/half into the read word → WR.
- WR: `mem_w_enable`=1, `mem_wdata`=merged word (or `req_wdata` for SW) → RESP.
- RESP: `resp_valid`=1 → IDLE when `resp_ready`.

Error conditions:
- Illegal: funct3 ∈ {011,110,111}, or a store with funct3[2]=1.
- Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.

Extraction and merge:
- Byte lane = addr[1:0]; half lane = addr[1].
- Loads: LB/LH sign-extend, LBU/LHU zero-extend.
- Stores: write `req_wdata[7:0]` / `[15:0]` into the selected lane; other lanes keep their read values.

Output rules:
- Memory strobes are decoded from the state register only (no combinational path from `req_*`).
- At most one strobe is high in any cycle.
- `resp_rdata` and `resp_err` are registered and stable while `resp_valid`=1.

## Timing
Reset values:
- State = IDLE, `req_ready`=1.
- `resp_valid`, `resp_err`, `resp_rdata`, `mem_r_enable`, `mem_w_enable`, `mem_addr`, `mem_wdata` = 0.

Latency, counted from the accepting edge to the first `resp_valid` cycle:
- Error: 1 cycle.
- SW: 2 cycles.
- Loads: 3 cycles.
- SB/SH: 4 cycles.

Handshake and boundary rules:
- Back-pressure: RESP holds indefinitely with outputs stable; there is no memory traffic while waiting.
- No new request is accepted until the cycle after the response handshake (IDLE again).
- Reset mid-operation: immediate return to IDLE and all strobes drop. A RMW interrupted before WR performs no write; the write itself is single-cycle, so partial writes cannot occur.
- `req_valid` without an accepting IDLE cycle is ignored; the requester holds it.

## Structure
Package `lsu_pkg` holds:
- funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
- the state enum {IDLE, RD, CAP, WR, RESP};
- the `is_misaligned`/`is_illegal` functions.

One sub-module, `lsu_align`, is purely combinational:
- load extract and extend (word, lane, funct3 → result);
- store merge (old word, new data, lane, funct3 → word).

The top level holds the FSM and the request/response registers.

## Test plan
Preload word 0xFF0F0E0D at byte address 0x19C. Expected responses:
- LB 0x19F → `resp_rdata`=0xFFFFFFFF.
- LBU 0x19F → `resp_rdata`=0x000000FF.
- LH 0x19E → `resp_rdata`=0xFFFFFF0F.
- LW 0x19C → `resp_rdata`=0xFF0F0E0D; `resp_valid` exactly 3 cycles after accept.
- SB 0xAA at 0x19D → one read then one write of 0xFF0FAA0D; LW then returns 0xFF0FAA0D. SW 0x12345678 at 0x1A0 → a single write strobe and no read, `resp_valid` 2 cycles after accept.
- LW 0x19A, SH 0x19D, and funct3=011 → `resp_err`=1, `resp_rdata`=0, no `mem_r_enable`/`mem_w_enable` ever high, 1-cycle latency.
- `resp_ready` held low for 5 cycles after LW → `resp_valid`, `resp_rdata` and `req_ready`=0 stable; no strobes during the wait.
- Assert `rst` during the CAP cycle of SB 0xAA to 0x19D → no write strobe; outputs at reset values; a later LW 0x19C returns 0xFF0F0E0D.
